seg_display_ctrl: RTL and testbench

Parametrised multiplexed seven-segment display controller for the RISC-V board wrapper. Drives `N_DIGITS` common-anode digits from a packed hex word, with tear-free frame updates, per-digit enables, decimal points, blink mode and a HALT indication mode. It sits between the core's memory-mapped display register and the board `seg`/`an` pins.

---
 rtl/seg_pkg.sv | 13 +
 rtl/seg_hex_decode.sv | 34 +++
 rtl/seg_display_ctrl.sv | 145 ++++++++++++++
 tb/tb_seg_display_ctrl.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment display controller.
package seg_pkg;

  localparam logic [1:0] MODE_HEX   = 2'd0;
  localparam logic [1:0] MODE_HALT  = 2'd1;
  localparam logic [1:0] MODE_BLANK = 2'd2;
  localparam logic [1:0] MODE_BLINK = 2'd3;

  // Active-low segment patterns: everything dark, everything lit
  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [6:0] SEG_ALL = 7'h00;

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to active-low seven-segment decoder.
// Bit 0 is segment a, bit 6 is segment g.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Standard 0-F glyph table, active-low
  always_comb begin
    seg = SEG_OFF;
    case (nibble)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg_display_ctrl.sv
// Multiplexed seven-segment display controller.
// Scans N_DIGITS common-anode digits, holding each for REFRESH_DIV cycles.
// New data is staged in a pending register and promoted to the active
// register only at a frame wrap, so a frame never shows a mix of old and new.
module seg_display_ctrl
  import seg_pkg::*;
#(
  parameter int N_DIGITS    = 4,
  parameter int REFRESH_DIV = 65536,
  parameter int BLINK_DIV   = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [4*N_DIGITS-1:0] wr_data,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic [N_DIGITS-1:0]   digit_en,
  input  logic [1:0]            mode,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [N_DIGITS-1:0]   an,
  output logic                  upd_pending,
  output logic                  frame_tick
);

  localparam int REF_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = $clog2(N_DIGITS);
  localparam int BLK_W = $clog2(BLINK_DIV) + 1;

  localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);

  logic [REF_W-1:0]            ref_cnt;
  logic [IDX_W-1:0]            idx;
  logic [BLK_W-1:0]            blink_cnt;
  logic                        blink_ph;
  logic                        wrap_d;

  logic [N_DIGITS-1:0][3:0]    pend_nib;
  logic [N_DIGITS-1:0]         pend_dp;
  logic [N_DIGITS-1:0][3:0]    act_nib;
  logic [N_DIGITS-1:0]         act_dp;

  logic                        digit_end;
  logic                        frame_wrap;
  logic                        visible;
  logic [6:0]                  dec_seg;
  logic [6:0]                  seg_next;
  logic                        dp_next;
  logic [N_DIGITS-1:0]         an_next;

  assign digit_end  = (ref_cnt == REF_LAST);
  assign frame_wrap = digit_end && (idx == IDX_LAST);

  seg_hex_decode u_dec (
    .nibble (act_nib[idx]),
    .seg    (dec_seg)
  );

  // Refresh counter, digit index and blink phase advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_cnt   <= '0;
      idx       <= '0;
      blink_cnt <= '0;
      blink_ph  <= 1'b1;
    end else begin
      if (digit_end) begin
        ref_cnt <= '0;
        idx     <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        ref_cnt <= ref_cnt + 1'b1;
      end
      if (frame_wrap) begin
        if (blink_cnt == BLK_LAST) begin
          blink_cnt <= '0;
          blink_ph  <= ~blink_ph;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end
    end
  end

  // Pending/active data handoff; a write landing on the wrap bypasses pending
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_nib    <= '0;
      pend_dp     <= '0;
      act_nib     <= '0;
      act_dp      <= '0;
      upd_pending <= 1'b0;
    end else if (frame_wrap) begin
      upd_pending <= 1'b0;
      if (wr_en) begin
        act_nib <= wr_data;
        act_dp  <= dp_in;
      end else if (upd_pending) begin
        act_nib <= pend_nib;
        act_dp  <= pend_dp;
      end
    end else if (wr_en) begin
      pend_nib    <= wr_data;
      pend_dp     <= dp_in;
      upd_pending <= 1'b1;
    end
  end

  // Next output values for the digit currently selected by idx
  always_comb begin
    visible  = digit_en[idx] && (mode != MODE_BLANK) &&
               ((mode != MODE_BLINK) || blink_ph);
    seg_next = SEG_OFF;
    dp_next  = 1'b1;
    an_next  = '1;
    if (visible) begin
      an_next[idx] = 1'b0;
      if (mode == MODE_HALT) begin
        seg_next = SEG_ALL;
      end else begin
        seg_next = dec_seg;
        dp_next  = ~act_dp[idx];
      end
    end
  end

  // Output registers; frame_tick is delayed twice so it lines up with digit 0's first output cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg        <= SEG_OFF;
      dp         <= 1'b1;
      an         <= '1;
      wrap_d     <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      seg        <= seg_next;
      dp         <= dp_next;
      an         <= an_next;
      wrap_d     <= frame_wrap;
      frame_tick <= wrap_d;
    end
  end

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Self-checking bench for seg_display_ctrl with a time-based reference model.
module tb_seg_display_ctrl;

  localparam int ND    = 4;
  localparam int RD    = 4;
  localparam int BD    = 2;
  localparam int FRAME = ND * RD;

  localparam logic [13:0] RESET_VEC = {7'h7F, 1'b1, 4'hF, 1'b0, 1'b0};

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic [15:0] wr_data;
  logic [3:0]  dp_in;
  logic [3:0]  digit_en;
  logic [1:0]  mode;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        upd_pending;
  logic        frame_tick;

  int checks   = 0;
  int failures = 0;

  // Reference model state: edges since reset release plus the data registers
  int          k;
  logic [15:0] m_act;
  logic [3:0]  m_act_dp;
  logic [15:0] m_pend;
  logic [3:0]  m_pend_dp;
  bit          m_flag;
  logic [13:0] exp_vec;
  logic [13:0] obs;
  logic [6:0]  hex_tab [16];

  seg_display_ctrl #(
    .N_DIGITS    (ND),
    .REFRESH_DIV (RD),
    .BLINK_DIV   (BD)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .dp_in       (dp_in),
    .digit_en    (digit_en),
    .mode        (mode),
    .seg         (seg),
    .dp          (dp),
    .an          (an),
    .upd_pending (upd_pending),
    .frame_tick  (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign obs = {seg, dp, an, upd_pending, frame_tick};

  task automatic model_reset();
    k         = 0;
    m_act     = '0;
    m_act_dp  = '0;
    m_pend    = '0;
    m_pend_dp = '0;
    m_flag    = 1'b0;
    exp_vec   = RESET_VEC;
  endtask

  // Advance one clock; expected outputs come from elapsed time and the data rules
  task automatic tick();
    int         pre, di, wraps;
    bit         ph, vis;
    logic [3:0] nib;
    logic [6:0] e_seg;
    logic       e_dp;
    logic [3:0] e_an;
    logic       e_tick;
    pre   = k;
    di    = (pre / RD) % ND;
    wraps = pre / FRAME;
    ph    = ((wraps / BD) % 2) == 0;
    vis   = digit_en[di] && (mode != 2'd2) && ((mode != 2'd3) || ph);
    nib   = m_act[di*4 +: 4];
    e_seg = 7'h7F;
    e_dp  = 1'b1;
    e_an  = 4'hF;
    if (vis) begin
      e_an[di] = 1'b0;
      if (mode == 2'd1) begin
        e_seg = 7'h00;
      end else begin
        e_seg = hex_tab[nib];
        e_dp  = ~m_act_dp[di];
      end
    end
    e_tick = (pre > 0) && ((pre % FRAME) == 0);
    if (((pre + 1) % FRAME) == 0) begin
      if (wr_en) begin
        m_act    = wr_data;
        m_act_dp = dp_in;
      end else if (m_flag) begin
        m_act    = m_pend;
        m_act_dp = m_pend_dp;
      end
      m_flag = 1'b0;
    end else if (wr_en) begin
      m_pend    = wr_data;
      m_pend_dp = dp_in;
      m_flag    = 1'b1;
    end
    @(posedge clk);
    #1;
    k++;
    exp_vec = {e_seg, e_dp, e_an, m_flag, e_tick};
  endtask

  task automatic test_reset();
    int ticks;
    rst_n    = 1'b0;
    wr_en    = 1'b0;
    wr_data  = '0;
    dp_in    = '0;
    digit_en = 4'hF;
    mode     = 2'd0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (obs !== RESET_VEC) begin
      failures++;
      $display("[TB] FAIL reset_values got=%h exp=%h", obs, RESET_VEC);
    end
    rst_n = 1'b1;
    ticks = 0;
    for (int i = 0; i < 64; i++) begin
      tick();
      if (frame_tick) ticks++;
      checks++;
      if (obs !== exp_vec) begin
        failures++;
        $display("[TB] FAIL reset_scan k=%0d got=%h exp=%h", k, obs, exp_vec);
      end
    end
    checks++;
    if (ticks !== 3) begin
      failures++;
      $display("[TB] FAIL frame_tick_count got=%0d exp=3", ticks);
    end
  endtask

  task automatic test_write_mid_frame();
    bit seen;
    while ((k % FRAME) != 5) tick();
    wr_en   = 1'b1;
    wr_data = 16'h1234;
    dp_in   = 4'b0010;
    tick();
    wr_en = 1'b0;
    seen  = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      checks++;
      if (obs !== exp_vec) begin
        failures++;
        $display("[TB] FAIL write_mid k=%0d got=%h exp=%h", k, obs, exp_vec);
      end
      if (!seen && (k % FRAME) == 1) begin
        seen = 1'b1;
        checks++;
        if (seg !== 7'h19) begin
          failures++;
          $display("[TB] FAIL write_mid_digit0 got=%h exp=19", seg);
        end
      end
    end
  endtask

  task automatic test_wrap_write();
    bit seen;
    while (((k + 1) % FRAME) != 0) tick();
    wr_en   = 1'b1;
    wr_data = 16'hABCD;
    dp_in   = 4'b0000;
    tick();
    wr_en = 1'b0;
    checks++;
    if (upd_pending !== 1'b0) begin
      failures++;
      $display("[TB] FAIL wrap_write_pending got=%b exp=0", upd_pending);
    end
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (obs !== exp_vec) begin
        failures++;
        $display("[TB] FAIL wrap_write k=%0d got=%h exp=%h", k, obs, exp_vec);
      end
      if (!seen && (k % FRAME) == 1) begin
        seen = 1'b1;
        checks++;
        if (seg !== 7'h21) begin
          failures++;
          $display("[TB] FAIL wrap_write_digit0 got=%h exp=21", seg);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    while ((k % FRAME) != 3) tick();
    for (int i = 0; i < 3; i++) begin
      wr_en   = 1'b1;
      wr_data = 16'($urandom);
      dp_in   = 4'($urandom);
      tick();
      checks++;
      if (obs !== exp_vec) begin
        failures++;
        $display("[TB] FAIL b2b_write k=%0d got=%h exp=%h", k, obs, exp_vec);
      end
    end
    wr_en = 1'b0;
    for (int i = 0; i < 32; i++) begin
      tick();
      checks++;
      if (obs !== exp_vec) begin
        failures++;
        $display("[TB] FAIL b2b_scan k=%0d got=%h exp=%h", k, obs, exp_vec);
      end
    end
  endtask

  task automatic test_digit_en();
    digit_en = 4'b0101;
    for (int i = 0; i < 34; i++) begin
      tick();
      checks++;
      if (obs !== exp_vec) begin
        failures++;
        $display("[TB] FAIL digit_en k=%0d got=%h exp=%h", k, obs, exp_vec);
      end
    end
    digit_en = 4'hF;
  endtask

  task automatic test_halt_blank();
    mode = 2'd1;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (obs !== exp_vec) begin
        failures++;
        $display("[TB] FAIL halt k=%0d got=%h exp=%h", k, obs, exp_vec);
      end
    end
    mode = 2'd2;
    tick();
    checks++;
    if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1) begin
      failures++;
      $display("[TB] FAIL blank_next got an=%h seg=%h dp=%b exp an=f seg=7f dp=1", an, seg, dp);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (obs !== exp_vec) begin
        failures++;
        $display("[TB] FAIL blank k=%0d got=%h exp=%h", k, obs, exp_vec);
      end
    end
  endtask

  task automatic test_blink();
    mode = 2'd3;
    for (int i = 0; i < 140; i++) begin
      tick();
      checks++;
      if (obs !== exp_vec) begin
        failures++;
        $display("[TB] FAIL blink k=%0d got=%h exp=%h", k, obs, exp_vec);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      wr_en = ($urandom_range(0, 3) == 0);
      wr_data = 16'($urandom);
      dp_in   = 4'($urandom);
      if ($urandom_range(0, 15) == 0) digit_en = 4'($urandom);
      if ($urandom_range(0, 31) == 0) mode = 2'($urandom);
      tick();
      checks++;
      if (obs !== exp_vec) begin
        failures++;
        $display("[TB] FAIL random k=%0d got=%h exp=%h", k, obs, exp_vec);
      end
    end
    wr_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    mode     = 2'd0;
    digit_en = 4'hF;
    while ((k % FRAME) != 6) tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== RESET_VEC) begin
      failures++;
      $display("[TB] FAIL reset_async got=%h exp=%h", obs, RESET_VEC);
    end
    model_reset();
    @(posedge clk);
    #1;
    checks++;
    if (obs !== RESET_VEC) begin
      failures++;
      $display("[TB] FAIL reset_hold got=%h exp=%h", obs, RESET_VEC);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 24; i++) begin
      tick();
      checks++;
      if (obs !== exp_vec) begin
        failures++;
        $display("[TB] FAIL reset_restart k=%0d got=%h exp=%h", k, obs, exp_vec);
      end
    end
  endtask

  initial begin
    hex_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    test_reset();
    test_write_mid_frame();
    test_wrap_write();
    test_back_to_back();
    test_digit_en();
    test_halt_blank();
    test_blink();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
